// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit/digit-serial subtractor: FSM state encoding and
// the digit-counter width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Never returns 0 so a single-digit configuration still gets a 1-bit counter.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, bo = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & (b | bi)) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor, DIGIT bits per cycle, LSB slice first.
// Optional add mode (op port) enabled by defining SERIAL_SUBTRACTOR_ADD_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo
`ifdef SERIAL_SUBTRACTOR_ADD_EN
  ,
  input  logic             op
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic             accept;
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] slice_d;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Add mode reuses the subtractor: a + b + c == a - ~b - ~c with carry = ~borrow.
  assign chain[0] = borrow_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    logic cell_b;
    logic cell_bi;
    logic cell_bo;
    assign cell_b  = b_q[i] ^ op_q;
    assign cell_bi = chain[i] ^ op_q;
    full_subtractor u_fs (
      .a  (a_q[i]),
      .b  (cell_b),
      .bi (cell_bi),
      .d  (slice_d[i]),
      .bo (cell_bo)
    );
    assign chain[i+1] = cell_bo ^ op_q;
  end

`ifdef SERIAL_SUBTRACTOR_ADD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 1'b0;
    end else if (accept) begin
      op_q <= op;
    end
  end
`else
  assign op_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      diff      <= '0;
      bo        <= 1'b0;
      cnt       <= '0;
      borrow_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        RUN: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          borrow_q <= chain[DIGIT];
          diff     <= (diff >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            bo        <= chain[DIGIT];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Acceptance overrides the DONE->IDLE return so back-to-back ops skip IDLE.
      if (accept) begin
        a_q      <= in1;
        b_q      <= in2;
        borrow_q <= bi;
        cnt      <= '0;
        state    <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 instances with DIGIT=1 and DIGIT=4.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in1 = '0, in2 = '0;
  logic       bi = 1'b0, op = 1'b0;
  logic       iv1 = 1'b0, or1 = 1'b0, ir1, ov1, bo1;
  logic       iv4 = 1'b0, or4 = 1'b0, ir4, ov4, bo4;
  logic [7:0] d1, d4;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in1(in1), .in2(in2), .bi(bi),
    .out_valid(ov1), .out_ready(or1), .diff(d1), .bo(bo1)
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    , .op(op)
`endif
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in1(in1), .in2(in2), .bi(bi),
    .out_valid(ov4), .out_ready(or4), .diff(d4), .bo(bo4)
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    , .op(op)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] d;
    logic       borrow;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic o, output logic [7:0] d, output logic borrow);
    int r;
    if (o) r = int'(a) + int'(b) + int'(c);
    else   r = int'(a) - int'(b) - int'(c);
    d      = 8'(r);
    borrow = o ? (r > 255) : (r < 0);
  endfunction

  // One full transaction on the selected instance (sel=1 -> DIGIT=4).
  task automatic txn(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic o, input logic [7:0] ed, input logic eb, input string name);
    int lat;
    in1 = a; in2 = b; bi = c; op = o;
    if (sel) iv4 = 1'b1; else iv1 = 1'b1;
    chk({name, "_in_ready"}, sel ? ir4 : ir1, 1);
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0;
    in1 = 8'($urandom); in2 = 8'($urandom); bi = 1'($urandom); op = 1'($urandom);
    lat = 0;
    while (!(sel ? ov4 : ov1) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, sel ? 2 : 8);
    chk({name, "_diff"}, sel ? d4 : d1, ed);
    chk({name, "_bo"}, sel ? bo4 : bo1, eb);
    if (sel) or4 = 1'b1; else or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0; or4 = 1'b0;
    chk({name, "_drop"}, sel ? ov4 : ov1, 0);
  endtask

  initial begin
    vec_t       vecs[5];
    logic [7:0] ed;
    logic       eb;
    int         lat;

    vecs[0] = '{a: 8'h05, b: 8'h03, c: 1'b0, d: 8'h02, borrow: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, c: 1'b0, d: 8'hFF, borrow: 1'b1};
    vecs[2] = '{a: 8'h80, b: 8'h7F, c: 1'b1, d: 8'h00, borrow: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, d: 8'hFF, borrow: 1'b1};
    vecs[4] = '{a: 8'hA5, b: 8'h5A, c: 1'b0, d: 8'h4B, borrow: 1'b0};

    #12;
    chk("rst_out_valid", ov1, 0);
    chk("rst_diff", d1, 0);
    chk("rst_bo", bo1, 0);
    chk("rst_in_ready", ir1, 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", ir1, 1);

    for (int i = 0; i < 5; i++)
      txn(1'b0, vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, vecs[i].d, vecs[i].borrow, $sformatf("vec%0d", i));

    txn(1'b1, 8'h3C, 8'hC3, 1'b0, 1'b0, 8'h79, 1'b1, "digit4");

`ifdef SERIAL_SUBTRACTOR_ADD_EN
    txn(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, "add_d1");
    txn(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, "add_d4");
`endif

    for (int i = 0; i < 30; i++) begin
      logic [7:0] a, b;
      logic       c, o;
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
`ifdef SERIAL_SUBTRACTOR_ADD_EN
      o = 1'($urandom);
`else
      o = 1'b0;
`endif
      model(a, b, c, o, ed, eb);
      txn(i % 3 == 0, a, b, c, o, ed, eb, $sformatf("rand%0d", i));
    end

    // Backpressure, then accept new operands in the same cycle the result is taken.
    in1 = 8'h10; in2 = 8'h20; bi = 1'b0; op = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; in1 = 8'hEE; in2 = 8'h77;
    lat = 0;
    while (!ov1 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", lat, 8);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", ov1, 1);
      chk("bp_hold_diff", d1, 8'hF0);
      chk("bp_hold_bo", bo1, 1);
      chk("bp_in_ready", ir1, 0);
      @(posedge clk); #1;
    end
    in1 = 8'h33; in2 = 8'h11; bi = 1'b0; iv1 = 1'b1; or1 = 1'b1;
    #1 chk("bp_same_cycle_ready", ir1, 1);
    @(posedge clk); #1;
    iv1 = 1'b0; or1 = 1'b0; in1 = 8'h00; in2 = 8'hFF;
    lat = 0;
    while (!ov1 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp_next_latency", lat, 8);
    chk("bp_next_diff", d1, 8'h22);
    chk("bp_next_bo", bo1, 0);
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;

    // Reset during the third RUN cycle must abandon the operation.
    in1 = 8'h55; in2 = 8'h11; bi = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", ov1, 0);
    chk("midrst_in_ready", ir1, 1);
    chk("midrst_diff", d1, 0);
    chk("midrst_bo", bo1, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_release_ready", ir1, 1);
    for (int k = 0; k < 12; k++) begin
      chk("midrst_no_stale", ov1, 0);
      @(posedge clk); #1;
    end

    model(8'h3C, 8'h0F, 1'b1, 1'b0, ed, eb);
    txn(1'b0, 8'h3C, 8'h0F, 1'b1, 1'b0, ed, eb, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per cycle; WIDTH % DIGIT == 0, else elaboration error.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port in1  input  WIDTH  minuend.
REQ-008 SHALL have port in2  input  WIDTH  subtrahend.
REQ-009 SHALL have port bi  input  1  borrow-in.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port diff  output  WIDTH  result.
REQ-013 SHALL have port bo  output  1  borrow-out.

Function
REQ-014 SHALL use a state machine with states IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-016 SHALL, on in_valid & in_ready, latch in1, in2 and bi, clear the digit counter, and enter RUN.
REQ-017 SHALL, in RUN, process one DIGIT-bit slice per cycle, LSB slice first, carrying borrow between slices in a register.
REQ-018 SHALL leave RUN for DONE after exactly N = WIDTH/DIGIT RUN cycles; out_valid rises on the Nth rising edge after the accepting edge.
REQ-019 SHALL produce diff = (in1 - in2 - bi) mod 2^WIDTH and bo = 1 iff in1 < in2 + bi (unsigned).
REQ-020 SHALL hold diff, bo and out_valid stable in DONE while out_ready is low.
REQ-021 SHALL, on out_valid & out_ready without a new acceptance, return to IDLE and deassert out_valid next cycle.
REQ-022 SHALL, on out_valid & out_ready & in_valid in the same cycle, accept the new operands and enter RUN directly; the old result is not repeated.
REQ-023 SHALL ignore in1/in2/bi changes outside the accepting cycle.
REQ-024 SHALL keep out_valid low in IDLE and RUN.

Reset
REQ-025 SHALL, on rst high, immediately force state IDLE, out_valid 0, diff 0, bo 0, counter 0, borrow register 0, independent of clk.
REQ-026 SHALL abandon any in-flight operation on reset; no result is emitted for it.
REQ-027 SHALL present in_ready = 1 on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL support macro SERIAL_SUBTRACTOR_ADD_EN.
REQ-029 SHALL, with SERIAL_SUBTRACTOR_ADD_EN defined, add port op (input, 1 bit), latched on acceptance: op=0 subtracts per REQ-019; op=1 gives diff = (in1 + in2 + bi) mod 2^WIDTH, with bo = carry-out.
REQ-030 SHALL, without SERIAL_SUBTRACTOR_ADD_EN, have no op port and always subtract.

Structure
REQ-031 SHALL take the state enum typedef (IDLE/RUN/DONE) and the counter-width constant function ($clog2(WIDTH/DIGIT)) from package serial_subtractor_pkg.
REQ-032 SHALL build the per-cycle slice from DIGIT instances of sub-module full_subtractor (a, b, bi -> d, bo), chained by borrow; in add mode, b and the borrow chain are inverted around the cell.

Verification (WIDTH=8 unless stated)
REQ-033 SHALL cover DIGIT=1, in1=0x05, in2=0x03, bi=0: diff=0x02, bo=0, and out_valid exactly 8 cycles after the accepting edge.
REQ-034 SHALL cover in1=0x00, in2=0x01, bi=0: diff=0xFF, bo=1 (wrap-around); and in1=0x80, in2=0x7F, bi=1: diff=0x00, bo=0.
REQ-035 SHALL cover backpressure: out_ready low for 5 cycles, then diff/bo/out_valid hold and in_ready=0; then out_ready=1 with in_valid=1, so the new operands are accepted in the same cycle and out_valid drops for 8 cycles.
REQ-036 SHALL cover rst asserted on the 3rd RUN cycle: out_valid=0 and state IDLE immediately, in_ready=1 after release, and no stale result appears.
REQ-037 SHALL cover DIGIT=4: in1=0x3C, in2=0xC3, bi=0 gives diff=0x79, bo=1, with latency 2 cycles.
REQ-038 SHALL cover SERIAL_SUBTRACTOR_ADD_EN with op=1, in1=0xFF, in2=0x01, bi=0: diff=0x00, bo=1.
